// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and write-back select for the
// 32-bit ARM pipeline.
//
// It captures the memory stage's results and holds them while freeze is
// high. On flush it loads a bubble. The register-file write port is driven
// combinationally from the registered fields only.
//
// Ports:
//   clk, rst         pipeline clock; asynchronous active-low reset
//   freeze, flush    hold / bubble controls, sampled at the rising edge
//   valid_in, mem_read_in, WB_en_in, dst_in, ALU_res_in, mem_data_in
//                    results presented by the memory stage
//   perf_clr         synchronous clear of retire_cnt (PERF_CNT_EN only)
//   valid_out        registered valid
//   WB_en            register-file write enable (WB_en_r & valid_r)
//   WB_dest          registered destination register
//   WB_value         load data when mem_read_r is set, otherwise ALU result
//   retire_cnt       saturating count of retired write-backs (PERF_CNT_EN only)
//
// Configuration macro: PERF_CNT_EN. When it is defined, the build adds the
// retire counter, the perf_clr input and the retire_cnt output.
//
// Flow control: there is no valid/ready handshake. The upstream stage must
// present stable inputs at the sampling edge. The hazard unit owns freeze
// and flush, and nothing here back-pressures.

module mem_wb_stage #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_FILE_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic                      mem_read_in,
    input  logic                      WB_en_in,
    input  logic [REG_FILE_DEPTH-1:0] dst_in,
    input  logic [WORD_WIDTH-1:0]     ALU_res_in,
    input  logic [WORD_WIDTH-1:0]     mem_data_in,
`ifdef PERF_CNT_EN
    input  logic                      perf_clr,
    output logic [31:0]               retire_cnt,
`endif
    output logic                      valid_out,
    output logic                      WB_en,
    output logic [REG_FILE_DEPTH-1:0] WB_dest,
    output logic [WORD_WIDTH-1:0]     WB_value
);

    logic                      valid_r;
    logic                      mem_read_r;
    logic                      WB_en_r;
    logic [REG_FILE_DEPTH-1:0] dst_r;
    logic [WORD_WIDTH-1:0]     ALU_res_r;
    logic [WORD_WIDTH-1:0]     mem_data_r;

    // Flush beats freeze. A bubble that is not valid is still captured, so
    // that the stale payload does not linger in the register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r    <= 1'b0;
            mem_read_r <= 1'b0;
            WB_en_r    <= 1'b0;
            dst_r      <= '0;
            ALU_res_r  <= '0;
            mem_data_r <= '0;
        end else if (flush) begin
            valid_r    <= 1'b0;
            mem_read_r <= 1'b0;
            WB_en_r    <= 1'b0;
            dst_r      <= '0;
            ALU_res_r  <= '0;
            mem_data_r <= '0;
        end else if (!freeze) begin
            valid_r    <= valid_in;
            mem_read_r <= mem_read_in;
            WB_en_r    <= WB_en_in;
            dst_r      <= dst_in;
            ALU_res_r  <= ALU_res_in;
            mem_data_r <= mem_data_in;
        end
    end

    // A frozen instruction keeps WB_en high for each frozen cycle. Writing
    // the same value again is harmless.
    assign valid_out = valid_r;
    assign WB_en     = WB_en_r & valid_r;
    assign WB_dest   = dst_r;
    assign WB_value  = mem_read_r ? mem_data_r : ALU_res_r;

`ifdef PERF_CNT_EN
    // Count an instruction on the edge where it is accepted. This way a
    // later freeze of that instruction cannot count it a second time.
    logic retire_evt;
    assign retire_evt = !flush && !freeze && valid_in && WB_en_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= '0;
        end else if (perf_clr) begin
            retire_cnt <= '0;
        end else if (retire_evt && (retire_cnt != 32'hFFFF_FFFF)) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
// The same PERF_CNT_EN macro as the design enables the retire-counter checks.

module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        valid_in;
    logic        mem_read_in;
    logic        WB_en_in;
    logic [3:0]  dst_in;
    logic [31:0] ALU_res_in;
    logic [31:0] mem_data_in;
    logic        valid_out;
    logic        WB_en;
    logic [3:0]  WB_dest;
    logic [31:0] WB_value;
`ifdef PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] retire_cnt;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    mem_wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .flush       (flush),
        .valid_in    (valid_in),
        .mem_read_in (mem_read_in),
        .WB_en_in    (WB_en_in),
        .dst_in      (dst_in),
        .ALU_res_in  (ALU_res_in),
        .mem_data_in (mem_data_in),
`ifdef PERF_CNT_EN
        .perf_clr    (perf_clr),
        .retire_cnt  (retire_cnt),
`endif
        .valid_out   (valid_out),
        .WB_en       (WB_en),
        .WB_dest     (WB_dest),
        .WB_value    (WB_value)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp);
`ifdef PERF_CNT_EN
        check(tag, retire_cnt, exp);
`else
        if (exp == 32'hFFFF_FFFF) $display("note: %s", tag); // counter absent in this build
`endif
    endtask

    // drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic mr, input logic we, input logic [3:0] d,
                         input logic [31:0] alu, input logic [31:0] md);
        valid_in    = v;
        mem_read_in = mr;
        WB_en_in    = we;
        dst_in      = d;
        ALU_res_in  = alu;
        mem_data_in = md;
    endtask

    task automatic check_out(input string tag, input logic v, input logic we, input logic [3:0] d,
                             input logic [31:0] val);
        check({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, v});
        check({tag, ".WB_en"},     {31'd0, WB_en},     {31'd0, we});
        check({tag, ".WB_dest"},   {28'd0, WB_dest},   {28'd0, d});
        check({tag, ".WB_value"},  WB_value,           val);
    endtask

    initial begin
        rst    = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
`ifdef PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        drive(1'b1, 1'b1, 1'b1, 4'h9, 32'h1111_1111, 32'h2222_2222);

        // Reset held across edges with live inputs.
        step();
        step();
        check_out("reset_hold", 1'b0, 1'b0, 4'h0, 32'h0);
        check_cnt("reset_hold.cnt", 32'd0);

        // Load write-back.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 4'h5, 32'h0000_0100, 32'hDEAD_BEEF);
        step();
        check_out("load", 1'b1, 1'b1, 4'h5, 32'hDEAD_BEEF);
        check_cnt("load.cnt", 32'd1);

        // ALU write-back. Load data stays on the bus but must not be selected.
        drive(1'b1, 1'b0, 1'b1, 4'hE, 32'h0000_002A, 32'hDEAD_BEEF);
        step();
        check_out("alu", 1'b1, 1'b1, 4'hE, 32'h0000_002A);
        check_cnt("alu.cnt", 32'd2);

        // Valid instruction without a register write.
        drive(1'b1, 1'b0, 1'b0, 4'h2, 32'h0000_0055, 32'h0);
        step();
        check_out("no_wb", 1'b1, 1'b0, 4'h2, 32'h0000_0055);
        check_cnt("no_wb.cnt", 32'd2);

        // Invalid slot with WB_en_in set: the write enable is masked.
        drive(1'b0, 1'b1, 1'b1, 4'h6, 32'h0000_0066, 32'hCAFE_F00D);
        step();
        check_out("invalid", 1'b0, 1'b0, 4'h6, 32'hCAFE_F00D);
        check_cnt("invalid.cnt", 32'd2);

        // Freeze for three edges while the inputs change.
        drive(1'b1, 1'b0, 1'b1, 4'h3, 32'h0000_0033, 32'h0);
        step();
        check_out("pre_freeze", 1'b1, 1'b1, 4'h3, 32'h0000_0033);
        freeze = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 4'h7, 32'h0000_0077, 32'h7777_7777);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("freeze%0d", i), 1'b1, 1'b1, 4'h3, 32'h0000_0033);
        end
        check_cnt("freeze.cnt", 32'd3);

        // Flush and freeze on the same edge: flush wins.
        flush = 1'b1;
        step();
        check_out("flush_freeze", 1'b0, 1'b0, 4'h0, 32'h0);
        check_cnt("flush_freeze.cnt", 32'd3);

        // Release both controls. The held inputs now load.
        flush  = 1'b0;
        freeze = 1'b0;
        step();
        check_out("release", 1'b1, 1'b1, 4'h7, 32'h7777_7777);
        check_cnt("release.cnt", 32'd4);

        // Asynchronous reset mid-cycle while frozen, with no clock edge.
        freeze = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 1'b0, 4'h0, 32'h0);
        check_cnt("async_rst.cnt", 32'd0);
        step();
        rst = 1'b1;
        // The first edge after release honours freeze, so the register holds zero.
        step();
        check_out("post_rst_freeze", 1'b0, 1'b0, 4'h0, 32'h0);
        freeze = 1'b0;
        step();
        check_out("post_rst_run", 1'b1, 1'b1, 4'h7, 32'h7777_7777);
        check_cnt("post_rst_run.cnt", 32'd1);

`ifdef PERF_CNT_EN
        // Saturation: preload near the top, then apply three retire events.
        @(negedge clk);
        force dut.retire_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.retire_cnt;
        check("preload.cnt", retire_cnt, 32'hFFFF_FFFE);
        step();
        check("sat0.cnt", retire_cnt, 32'hFFFF_FFFF);
        step();
        check("sat1.cnt", retire_cnt, 32'hFFFF_FFFF);
        step();
        check("sat2.cnt", retire_cnt, 32'hFFFF_FFFF);
        // perf_clr together with a retire event: the clear wins.
        perf_clr = 1'b1;
        step();
        check("perf_clr.cnt", retire_cnt, 32'd0);
        perf_clr = 1'b0;
        step();
        check("after_clr.cnt", retire_cnt, 32'd1);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
